cpu_fetch: RTL and testbench
============================

# cpu_fetch

Instruction/immediate fetch stage feeding `cpu_ctrl`. Owns the program counter, the instruction register and the immediate register. Performs single-byte reads from program RAM over a req/ack handshake with variable latency. Produces the `instruction` byte and the `bus_ready` level that the control FSM consumes, and applies the FSM's `pc_inc`/`pc_load`/`pc_dec` strobes.

## Interface
Parameters:
- `ADDR_W`, 8: PC and memory address width.
- `WAIT_MAX`, 15: maximum `mem_ack` wait cycles before a bus timeout.
- `NOP_BYTE`, 8'h00: value loaded into IR on reset and on timeout.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `fetch_req` in 1: start a fetch; sampled only in IDLE or DONE.
- `fetch_imm` in 1: qualifies `fetch_req`; 0 = opcode to IR, 1 = immediate to IMM.
- `pc_inc` in 1: PC += 1.
- `pc_dec` in 1: PC -= 1.
- `pc_load` in 1: PC <= `pc_load_val`.
- `pc_load_val` in ADDR_W: jump/return target.
- `mem_addr` out ADDR_W: read address, latched at request.
- `mem_rd` out 1: read request, held until ack.
- `mem_rdata` in 8: read data, valid with `mem_ack`.
- `mem_ack` in 1: one-cycle read completion.
- `pc` out ADDR_W: current program counter.
- `instruction` out 8: IR contents.
- `imm` out 8: immediate register.
- `bus_ready` out 1: last requested fetch complete, data valid.
- `bus_err` out 1: sticky timeout flag.

## Operation
States:
- **IDLE**
  - `fetch_req` -> REQ.
  - In REQ: latch `mem_addr <= pc`, latch kind, clear `bus_ready`.
- **REQ**
  - `mem_rd` = 1.
  - `mem_ack` -> DONE, with same-cycle ack allowed.
  - Otherwise -> WAIT, timer = 1.
- **WAIT**
  - `mem_rd` stays 1.
  - `mem_ack` -> DONE.
  - Timer reaching WAIT_MAX without ack -> DONE with timeout.
- **DONE**
  - `bus_ready` = 1, held until the next accepted `fetch_req`.
  - New `fetch_req` -> REQ directly.
  - Otherwise stays in DONE.

Data capture:
- On ack, `mem_rdata` is written to IR (kind 0) or IMM (kind 1), never both.
- On timeout, IR gets `NOP_BYTE` (kind 0) or IMM gets 8'h00 (kind 1), and `bus_err` is set.
- `bus_err` clears only on reset.

PC update, every cycle regardless of fetch state:
- Priority: `pc_load` > `pc_inc` > `pc_dec`.
- Arithmetic is modulo 2^ADDR_W: 0xFF+1 = 0x00, 0x00-1 = 0xFF.
- PC changes during REQ/WAIT do not alter `mem_addr`; the in-flight address is frozen.

Ignored inputs:
- `fetch_req` in REQ/WAIT is ignored (no queueing).
- `mem_ack` outside REQ/WAIT is ignored.

Reset values:
- state IDLE; pc 0; `instruction` = `NOP_BYTE`; `imm` 0.
- `mem_addr` 0; `mem_rd` 0; `bus_ready` 0; `bus_err` 0.
- Reset mid-fetch drops `mem_rd` immediately (asynchronous) and discards any late ack.

## Timing
- All outputs are registered.
- `fetch_req` at edge N -> `mem_rd`/`mem_addr` valid after N.
- Ack sampled at edge M -> IR/IMM and `bus_ready` valid after M.
- Zero-wait RAM (ack in the first REQ cycle): `bus_ready` rises 2 cycles after `fetch_req`.
- Timeout: `bus_ready` rises WAIT_MAX+2 cycles after `fetch_req`.
- The FSM raises `pc_inc` while in FETCH_INST/WAIT_IMM with `bus_ready`=1. This block applies each asserted `pc_inc` cycle exactly once; the FSM is responsible for pulse width.
- `instruction` stays stable from DONE until the next opcode capture, so the controller's NEXT-state latch sees a stable IR.

## Structure
- Shared package `cpu_pkg`:
  - fetch-state enum (IDLE/REQ/WAIT/DONE);
  - `NOP_BYTE` default;
  - ADDR_W default.
- One natural sub-module: `pc_reg`, holding the PC register with load/inc/dec priority and wrap.
- Handshake FSM, wait timer and IR/IMM capture stay in `cpu_fetch`.

## Test plan
- Reset release:
  - Stimulus: `fetch_req`=1, `fetch_imm`=0, RAM[0]=8'h10, zero-wait ack.
  - Expected: `mem_addr`=0, `instruction`=8'h10 and `bus_ready`=1 two cycles after the request, `imm` unchanged.
- 3-cycle RAM latency:
  - Stimulus: pc=0x05, `fetch_imm`=1, RAM[5]=8'hA7.
  - Expected: `mem_rd` held high 4 cycles, `imm`=8'hA7, `instruction` unchanged, `bus_ready` low throughout wait.
- PC priority and wrap:
  - Stimulus: pc=0xFF with `pc_inc`, expect 0x00; `pc_load`+`pc_inc` with val 0x40, expect 0x40; `pc_dec` at 0x00, expect 0xFF.
- Address freeze:
  - Stimulus: `pc_load` to 0x30 while WAIT on address 0x07.
  - Expected: `mem_addr` stays 0x07, captured data is RAM[7]; the next fetch uses 0x30.
- Timeout:
  - Stimulus: no ack for WAIT_MAX cycles.
  - Expected: `bus_err`=1, `instruction`=8'h00, `bus_ready`=1, `mem_rd`=0. A later successful fetch leaves `bus_err`=1.
- Mid-fetch reset:
  - Stimulus: `reset_n` low during WAIT, late `mem_ack` after release.
  - Expected: `mem_rd` drops immediately, IR=`NOP_BYTE`, the ack is ignored, state is IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and defaults for the CPU fetch/control slice.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W   = 8;
  localparam logic [7:0]  CPU_NOP_BYTE = 8'h00;

  // Handshake states of the fetch unit
  typedef enum logic [1:0] {
    FS_IDLE,
    FS_REQ,
    FS_WAIT,
    FS_DONE
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: load beats increment beats decrement, modulo 2^ADDR_W.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              inc,
  input  logic              dec,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  // PC update with fixed priority; natural wrap of the fixed-width adder
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end else if (dec) begin
      pc <= pc - ADDR_W'(1);
    end
  end

endmodule

// File: rtl/cpu_fetch.sv
// Instruction/immediate fetch stage: PC, IR and IMM, single-byte reads over a
// req/ack bus with a bounded wait and a sticky timeout flag.
module cpu_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = CPU_ADDR_W,
  parameter int unsigned WAIT_MAX = 15,
  parameter logic [7:0]  NOP_BYTE = CPU_NOP_BYTE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic              fetch_imm,
  input  logic              pc_inc,
  input  logic              pc_dec,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        instruction,
  output logic [7:0]        imm,
  output logic              bus_ready,
  output logic              bus_err
);

  localparam int unsigned TW = $clog2(WAIT_MAX + 1);

  fetch_state_t  state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic          kind;
  logic          start;
  logic          capture;
  logic          timeout;

  pc_reg #(
    .ADDR_W(ADDR_W)
  ) u_pc_reg (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (pc_load),
    .inc      (pc_inc),
    .dec      (pc_dec),
    .load_val (pc_load_val),
    .pc       (pc)
  );

  // Handshake state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, wait timer and capture/timeout strobes
  always_comb begin
    state_next = state;
    timer_next = timer;
    start      = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    case (state)
      FS_IDLE, FS_DONE: begin
        if (fetch_req) begin
          start      = 1'b1;
          state_next = FS_REQ;
        end
      end
      FS_REQ: begin
        if (mem_ack) begin
          capture    = 1'b1;
          state_next = FS_DONE;
        end else begin
          timer_next = TW'(1);
          state_next = FS_WAIT;
        end
      end
      FS_WAIT: begin
        // an ack on the final wait cycle still wins over the timeout
        if (mem_ack) begin
          capture    = 1'b1;
          state_next = FS_DONE;
        end else if (timer == TW'(WAIT_MAX)) begin
          timeout    = 1'b1;
          state_next = FS_DONE;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      default: state_next = FS_IDLE;
    endcase
  end

  // Registered bus outputs, IR/IMM capture and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer       <= '0;
      kind        <= 1'b0;
      mem_addr    <= '0;
      mem_rd      <= 1'b0;
      instruction <= NOP_BYTE;
      imm         <= '0;
      bus_ready   <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      timer  <= timer_next;
      mem_rd <= (state_next == FS_REQ) || (state_next == FS_WAIT);
      if (start) begin
        mem_addr  <= pc;
        kind      <= fetch_imm;
        bus_ready <= 1'b0;
      end
      if (capture) begin
        if (kind) begin
          imm <= mem_rdata;
        end else begin
          instruction <= mem_rdata;
        end
        bus_ready <= 1'b1;
      end
      if (timeout) begin
        if (kind) begin
          imm <= '0;
        end else begin
          instruction <= NOP_BYTE;
        end
        bus_ready <= 1'b1;
        bus_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_fetch.sv
// Scoreboard bench for cpu_fetch: randomized fetches and PC strobes against a
// behavioural model, a latency-programmable RAM responder and a checking monitor.
module tb_cpu_fetch;

  localparam int unsigned WAIT_MAX = 15;
  localparam logic [7:0]  NOP      = 8'h00;

  logic       clk;
  logic       reset_n;
  logic       fetch_req;
  logic       fetch_imm;
  logic       pc_inc;
  logic       pc_dec;
  logic       pc_load;
  logic [7:0] pc_load_val;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic [7:0] pc;
  logic [7:0] instruction;
  logic [7:0] imm;
  logic       bus_ready;
  logic       bus_err;

  cpu_fetch #(
    .ADDR_W   (8),
    .WAIT_MAX (WAIT_MAX),
    .NOP_BYTE (NOP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fetch_req   (fetch_req),
    .fetch_imm   (fetch_imm),
    .pc_inc      (pc_inc),
    .pc_dec      (pc_dec),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .pc          (pc),
    .instruction (instruction),
    .imm         (imm),
    .bus_ready   (bus_ready),
    .bus_err     (bus_err)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] instr;
    logic [7:0] imm;
    logic       err;
  } exp_t;

  exp_t        exp_q[$];
  int          lat_q[$];
  logic [7:0]  ram [256];
  int unsigned model_pc;
  logic [7:0]  m_instr;
  logic [7:0]  m_imm;
  logic        m_err;
  bit          late_ack;
  int          errors;
  int          checks;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, model the PC at the rising edge, check PC after
  task automatic cycle(input bit ld, input bit inc, input bit dec, input logic [7:0] val,
                       input bit freq, input bit fimm);
    pc_load     = ld;
    pc_inc      = inc;
    pc_dec      = dec;
    pc_load_val = val;
    fetch_req   = freq;
    fetch_imm   = fimm;
    @(posedge clk);
    if (ld)       model_pc = val;
    else if (inc) model_pc = (model_pc + 1) % 256;
    else if (dec) model_pc = (model_pc + 255) % 256;
    @(negedge clk);
    chk("pc", pc, model_pc);
  endtask

  // Random PC strobes; a stray fetch_req while a read is in flight must be ignored
  task automatic rand_cycle(input bit issue, input bit kind, input bit rnd);
    bit ld, inc, dec, freq, fimm;
    logic [7:0] v;
    ld = 0; inc = 0; dec = 0;
    v = 8'($urandom);
    if (rnd) begin
      case ($urandom % 8)
        0: ld = 1;
        1: inc = 1;
        2: dec = 1;
        3: begin ld = 1; inc = 1; end
        4: begin inc = 1; dec = 1; end
        5: begin ld = 1; dec = 1; end
        default: ;
      endcase
    end
    freq = issue ? 1'b1 : (rnd && mem_rd && ($urandom % 4 == 0));
    fimm = issue ? kind : 1'($urandom);
    cycle(ld, inc, dec, v, freq, fimm);
  endtask

  task automatic do_fetch(input bit kind, input int lat, input bit rnd,
                          input bit mid_en, input logic [7:0] mid_val);
    exp_t e;
    int n;
    bit ok;
    ok = (lat <= int'(WAIT_MAX));
    e.addr = model_pc[7:0];
    if (kind) m_imm   = ok ? ram[e.addr] : 8'h00;
    else      m_instr = ok ? ram[e.addr] : NOP;
    if (!ok) m_err = 1'b1;
    e.instr = m_instr;
    e.imm   = m_imm;
    e.err   = m_err;
    lat_q.push_back(lat);
    exp_q.push_back(e);
    rand_cycle(1'b1, kind, rnd);
    n = 0;
    while (!bus_ready && n < 40) begin
      if (mid_en && n == 0) cycle(1'b1, 1'b0, 1'b0, mid_val, 1'b0, 1'b0);
      else                  rand_cycle(1'b0, 1'b0, rnd);
      n++;
    end
    chk("ready_latency", n, ok ? lat + 1 : int'(WAIT_MAX) + 1);
  endtask

  // RAM responder: acks after the programmed number of cycles, plus stray acks when idle
  initial begin
    int cnt;
    int cur_lat;
    bit serving;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    serving = 0;
    cnt = 0;
    cur_lat = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (late_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 8'h5A;
        late_ack  = 0;
      end else if (!reset_n) begin
        serving = 0;
      end else if (mem_rd) begin
        if (!serving) begin
          serving = 1;
          cnt = 0;
          cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
        end
        if (cnt == cur_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = ram[mem_addr];
        end
        cnt++;
      end else begin
        serving = 0;
        if ($urandom % 8 == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = 8'($urandom);
        end
      end
    end
  end

  // Monitor: frozen address while reading; data and flags on each completion
  initial begin
    exp_t e;
    bit prev;
    prev = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = 0;
        continue;
      end
      if (mem_rd) begin
        if (exp_q.size() == 0) chk("mem_rd_unrequested", mem_rd, 0);
        else                   chk("mem_addr", mem_addr, exp_q[0].addr);
      end
      if (bus_ready && !prev) begin
        if (exp_q.size() == 0) begin
          chk("ready_unrequested", bus_ready, 0);
        end else begin
          e = exp_q.pop_front();
          chk("instruction", instruction, e.instr);
          chk("imm", imm, e.imm);
          chk("bus_err", bus_err, e.err);
          chk("mem_rd_done", mem_rd, 0);
        end
      end
      prev = bus_ready;
    end
  end

  initial begin
    exp_t e;
    int lat;
    errors = 0;
    checks = 0;
    late_ack = 0;
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    ram[0] = 8'h10;
    ram[5] = 8'hA7;
    model_pc = 0;
    m_instr = NOP;
    m_imm = 8'h00;
    m_err = 1'b0;
    reset_n = 1'b0;
    fetch_req = 0; fetch_imm = 0; pc_inc = 0; pc_dec = 0; pc_load = 0; pc_load_val = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_instruction", instruction, NOP);
    chk("rst_imm", imm, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_bus_ready", bus_ready, 0);
    chk("rst_bus_err", bus_err, 0);
    reset_n = 1'b1;

    // zero-wait opcode fetch from address 0
    do_fetch(1'b0, 0, 1'b0, 1'b0, 8'h00);
    chk("first_instr", instruction, 8'h10);

    // 3-cycle latency immediate fetch at 0x05
    cycle(1'b1, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0);
    do_fetch(1'b1, 3, 1'b0, 1'b0, 8'h00);
    chk("imm_a7", imm, 8'hA7);
    chk("instr_kept", instruction, 8'h10);

    // PC priority and wrap
    cycle(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("pc_wrap_inc", pc, 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 8'h40, 1'b0, 1'b0);
    chk("pc_load_prio", pc, 8'h40);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("pc_wrap_dec", pc, 8'hFF);

    // jump during the wait: address stays 0x07, next fetch comes from 0x30
    cycle(1'b1, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);
    do_fetch(1'b0, 3, 1'b0, 1'b1, 8'h30);
    do_fetch(1'b0, 1, 1'b0, 1'b0, 8'h00);

    // timeout, then a successful fetch must leave the error set
    do_fetch(1'b0, 40, 1'b0, 1'b0, 8'h00);
    do_fetch(1'b1, 2, 1'b0, 1'b0, 8'h00);

    // randomized traffic, including ack on the last wait cycle and one past it
    for (int i = 0; i < 60; i++) begin
      case ($urandom % 10)
        6:       lat = int'(WAIT_MAX);
        7:       lat = int'(WAIT_MAX) + 1;
        8:       lat = int'($urandom_range(5, 10));
        9:       lat = 25;
        default: lat = int'($urandom % 4);
      endcase
      do_fetch(1'($urandom), lat, 1'b1, 1'b0, 8'h00);
    end

    // reset during a wait; a late ack afterwards must be ignored
    e.addr = model_pc[7:0];
    e.instr = m_instr;
    e.imm = m_imm;
    e.err = m_err;
    exp_q.push_back(e);
    lat_q.push_back(100);
    rand_cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) rand_cycle(1'b0, 1'b0, 1'b0);
    chk("pre_reset_mem_rd", mem_rd, 1);
    #2;
    fetch_req = 0; pc_inc = 0; pc_dec = 0; pc_load = 0;
    reset_n = 1'b0;
    #1;
    chk("async_mem_rd", mem_rd, 0);
    chk("async_instruction", instruction, NOP);
    chk("async_bus_ready", bus_ready, 0);
    chk("async_pc", pc, 0);
    exp_q.delete();
    lat_q.delete();
    model_pc = 0;
    m_instr = NOP;
    m_imm = 8'h00;
    m_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    late_ack = 1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("late_ack_instruction", instruction, NOP);
    chk("late_ack_bus_ready", bus_ready, 0);
    chk("late_ack_mem_rd", mem_rd, 0);
    chk("late_ack_bus_err", bus_err, 0);
    do_fetch(1'b0, 0, 1'b0, 1'b0, 8'h00);
    chk("post_reset_instr", instruction, 8'h10);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
